systolic_semiring_array: RTL and testbench

Parametrised linear systolic array of N processing cells, each holding a stationary W-bit weight and a W-bit accumulator. Data words stream through a per-cycle shift pipeline, as in the single-bit shift cells, and each cell folds every passing word into its accumulator under a selectable semiring: modular, saturating, tropical (min,+) or boolean. Results are drained serially over a valid/ready port. The block is the datapath core of the processor top level, with commands fed from the dedicated inputs.

---
 rtl/systolic_semiring_array.sv | 158 +++++++++++++++
 tb/tb_systolic_semiring_array.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_semiring_array.sv
// Linear systolic array: stationary weights, data shifted one cell per cycle, per-cell semiring accumulate.
// Results are drained serially after an N-cycle flush; in_ready is low during flush and drain.
module systolic_semiring_array #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [W-1:0]  MAXV     = {W{1'b1}};
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [1:0]    state;
    logic [IW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [1:0]    mode_q;
    logic [W-1:0]  w   [N];
    logic [W-1:0]  acc [N];
    logic [W-1:0]  x   [N];
    logic [W-1:0]  acc_nxt [N];
    logic [N-1:0]  tag;

    logic accept, is_wload, is_data, is_clear, drain_done;

    function automatic logic [W-1:0] ident(input logic [1:0] m);
        return (m == 2'b10) ? MAXV : '0;
    endfunction

    function automatic logic [W-1:0] fold(input logic [1:0] m, input logic [W-1:0] a,
                                          input logic [W-1:0] wt, input logic [W-1:0] xv);
        logic [2*W-1:0] prod;
        logic [W:0]     s;
        logic [W-1:0]   p;
        logic [W-1:0]   r;
        prod = {{W{1'b0}}, wt} * {{W{1'b0}}, xv};
        s = '0;
        p = '0;
        r = '0;
        case (m)
            2'b00: begin
                p = prod[W-1:0];
                r = a + p;
            end
            2'b01: begin
                // product clamped before the saturating add
                p = (|prod[2*W-1:W]) ? MAXV : prod[W-1:0];
                s = {1'b0, a} + {1'b0, p};
                r = s[W] ? MAXV : s[W-1:0];
            end
            2'b10: begin
                s = {1'b0, wt} + {1'b0, xv};
                p = s[W] ? MAXV : s[W-1:0];
                r = (p < a) ? p : a;
            end
            default: r = a | (wt & xv);
        endcase
        return r;
    endfunction

    assign in_ready   = (state == ST_RUN);
    assign out_valid  = (state == ST_DRAIN);
    assign out_data   = acc[idx];
    assign out_last   = out_valid && (idx == LAST_IDX);

    assign accept     = in_valid && in_ready;
    assign is_wload   = accept && (in_op == 2'b00);
    assign is_data    = accept && (in_op == 2'b01);
    assign is_clear   = accept && (in_op == 2'b10);
    assign drain_done = out_valid && out_ready && out_last;

    // A CLEAR coinciding with an in-flight word folds that word onto the new identity.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            acc_nxt[j] = acc[j];
            if (is_clear)
                acc_nxt[j] = ident(mode);
            if (tag[j])
                acc_nxt[j] = fold(is_clear ? mode : mode_q, is_clear ? ident(mode) : acc[j], w[j], x[j]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N; j++) begin
                w[j]   <= '0;
                acc[j] <= '0;
                x[j]   <= '0;
            end
            tag    <= '0;
            state  <= ST_RUN;
            cnt    <= '0;
            idx    <= '0;
            mode_q <= 2'b00;
        end else begin
            tag <= {tag[N-2:0], is_data};
            if (is_data)
                x[0] <= in_data;
            for (int j = 1; j < N; j++)
                x[j] <= x[j-1];

            if (is_wload) begin
                w[0] <= in_data;
                for (int j = 1; j < N; j++)
                    w[j] <= w[j-1];
            end

            if (is_clear)
                mode_q <= mode;

            for (int j = 0; j < N; j++)
                acc[j] <= acc_nxt[j];

            case (state)
                ST_RUN: begin
                    if (is_data && in_last) begin
                        state <= ST_FLUSH;
                        cnt   <= '0;
                    end
                end
                ST_FLUSH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state <= ST_DRAIN;
                        idx   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        idx <= idx + 1'b1;
                        if (drain_done) begin
                            idx   <= '0;
                            state <= ST_RUN;
                            for (int j = 0; j < N; j++)
                                acc[j] <= ident(mode_q);
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_semiring_array.sv
// Directed bench for systolic_semiring_array with an integer reference model and a result queue.
module tb_systolic_semiring_array;

    localparam int W = 4;
    localparam int N = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_data;
    logic         in_last;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    systolic_semiring_array #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int l;
    } exp_t;

    exp_t q[$];
    int   w_m   [N];
    int   acc_m [N];
    int   mode_m;
    int   checks;
    int   errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_ident(input int md);
        return (md == 2) ? M - 1 : 0;
    endfunction

    function automatic int m_fold(input int md, input int a, input int wt, input int xv);
        int p;
        int s;
        case (md)
            0: return (a + wt * xv) % M;
            1: begin
                p = wt * xv;
                if (p > M - 1) p = M - 1;
                s = a + p;
                return (s > M - 1) ? M - 1 : s;
            end
            2: begin
                p = wt + xv;
                if (p > M - 1) p = M - 1;
                return (p < a) ? p : a;
            end
            default: return a | (wt & xv);
        endcase
    endfunction

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            w_m[j]   = 0;
            acc_m[j] = 0;
        end
        mode_m = 0;
        q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input int op, input int data, input int last, input int md);
        int n;
        exp_t e;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_wait", (n < 200), 1);
        in_valid = 1'b1;
        in_op    = 2'(op);
        in_data  = W'(data);
        in_last  = last[0];
        mode     = 2'(md);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        case (op)
            0: begin
                for (int j = N - 1; j > 0; j--) w_m[j] = w_m[j-1];
                w_m[0] = data;
            end
            1: begin
                for (int j = 0; j < N; j++) acc_m[j] = m_fold(mode_m, acc_m[j], w_m[j], data);
                if (last != 0) begin
                    for (int j = 0; j < N; j++) begin
                        e.d = acc_m[j];
                        e.l = (j == N - 1) ? 1 : 0;
                        q.push_back(e);
                        acc_m[j] = m_ident(mode_m);
                    end
                end
            end
            2: begin
                mode_m = md;
                for (int j = 0; j < N; j++) acc_m[j] = m_ident(md);
            end
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called right after the last DATA beat; consumes up to max_words results.
    task automatic drain(input bit bp, input int max_words);
        int lat;
        int got;
        bit seen;
        bit prev_stall;
        bit rdy;
        logic [W-1:0] hold_d;
        logic hold_l;
        exp_t e;
        lat = 0;
        got = 0;
        seen = 0;
        prev_stall = 0;
        hold_d = '0;
        hold_l = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            lat++;
            if (prev_stall) begin
                chk("hold_data", out_data, hold_d);
                chk("hold_last", out_last, hold_l);
            end
            chk("in_ready_busy", in_ready, 0);
            if (out_valid && !seen) begin
                seen = 1;
                chk("first_valid_latency", lat, N);
            end
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready  = rdy;
            prev_stall = out_valid && !rdy;
            hold_d = out_data;
            hold_l = out_last;
            if (out_valid && rdy) begin
                chk("queue_nonempty", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.l);
                end
                got++;
                if (e.l != 0 || got == max_words) begin
                    @(negedge clk);
                    out_ready = 1'b0;
                    if (e.l != 0) begin
                        chk("in_ready_after_drain", in_ready, 1);
                        chk("out_valid_after_drain", out_valid, 0);
                    end
                    return;
                end
            end
        end
        chk("drain_timeout", got, N);
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = '0;
        in_last   = 1'b0;
        mode      = 2'b00;
        out_ready = 1'b0;
        model_reset();
        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // modular; reserved op and non-CLEAR mode values must have no effect
        send(0, 1, 0, 0); send(0, 2, 0, 0); send(0, 3, 0, 0); send(0, 4, 0, 0);
        send(2, 0, 0, 0);
        send(1, 3, 0, 3);
        send(3, 9, 1, 2);
        send(1, 2, 1, 1);
        drain(0, N);

        // saturating
        send(2, 0, 0, 1);
        send(1, 3, 0, 0); send(1, 2, 1, 0);
        drain(0, N);

        // tropical, then a second run relying on the post-drain identity
        send(2, 0, 0, 2);
        send(1, 7, 0, 0); send(1, 3, 1, 0);
        drain(0, N);
        send(1, 14, 1, 0);
        drain(0, N);

        // boolean
        send(0, 'h0, 0, 0); send(0, 'hC, 0, 0); send(0, 'h3, 0, 0); send(0, 'hF, 0, 0);
        send(2, 0, 0, 3);
        send(1, 'h5, 0, 0); send(1, 'hA, 1, 0);
        drain(0, N);

        // bubbles and backpressure
        send(0, 1, 0, 0); send(0, 2, 0, 0); send(0, 3, 0, 0); send(0, 4, 0, 0);
        send(2, 0, 0, 0);
        send(1, 3, 0, 0); idle(3); send(1, 2, 1, 0);
        drain(1, N);
        send(2, 0, 0, 2);
        send(1, 7, 0, 0); idle(2); send(1, 3, 1, 0);
        drain(1, N);

        // random runs in every mode
        for (int md = 0; md < 4; md++) begin
            for (int k = 0; k < N; k++) send(0, $urandom_range(0, M - 1), 0, 0);
            send(2, 0, 0, md);
            for (int k = 0; k < 5; k++) begin
                send(1, $urandom_range(0, M - 1), (k == 4) ? 1 : 0, 0);
                if (k < 4) idle($urandom_range(0, 2));
            end
            drain(1, N);
        end

        // reset in the middle of a drain
        send(0, 1, 0, 0); send(0, 2, 0, 0); send(0, 3, 0, 0); send(0, 4, 0, 0);
        send(2, 0, 0, 0);
        send(1, 3, 0, 0); send(1, 2, 1, 0);
        drain(0, 2);
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_data", out_data, 0);
        chk("midreset_out_last", out_last, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1, 3, 0, 0); send(1, 5, 1, 0);
        drain(0, N);
        chk("queue_empty_at_end", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
